// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared definitions for the sequential multiply/divide unit.
//   state_t      - controller states (IDLE, MULT, DIV, FIX, DONE)
//   MULT_ITER    - Booth iterations per multiply
//   DIV_ITER     - restoring iterations per divide
//   MULT_LATENCY - start edge to done, multiply
//   DIV_LATENCY  - start edge to done, divide
package mult_div_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int unsigned MULT_ITER    = 32;
    localparam int unsigned DIV_ITER     = 32;
    localparam int unsigned MULT_LATENCY = 33;
    localparam int unsigned DIV_LATENCY  = 34;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// div_step: one unsigned restoring shift-subtract step (combinational).
// Ports:
//   rem      in  WIDTH : partial remainder
//   quo      in  WIDTH : dividend bits still to shift in / quotient bits so far
//   divisor  in  WIDTH : unsigned divisor
//   remNext  out WIDTH : remainder after this step
//   quoNext  out WIDTH : quotient after this step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remNext,
    output logic [WIDTH-1:0] quoNext
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        // rem < divisor always holds, so the shifted value fits in WIDTH+1 bits
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            remNext = trial[WIDTH-1:0];
            quoNext = {quo[WIDTH-2:0], 1'b1};
        end else begin
            remNext = shifted[WIDTH-1:0];
            quoNext = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed multiply (radix-2 Booth) and divide
// (restoring, sign-corrected) with internal HI/LO result registers.
// Ports:
//   clk, reset            : rising-edge clock, async active-high reset
//   start_mult, start_div : operation requests, sampled only in IDLE
//   a, b                  : operands, captured on the start edge
//   hi, lo                : product[63:32]/[31:0] or remainder/quotient
//   busy                  : operation in progress
//   done                  : one-cycle pulse, hi/lo valid from this cycle
//   div_zero              : one-cycle pulse with done on divide by zero
// Build option: MULT_DIV_DIVZERO_EN - short-circuit a zero divisor straight
// to DONE with div_zero set and hi/lo untouched; otherwise div_zero is 0
// and a zero divisor runs the full restoring sequence.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    state_t           state;
    logic [5:0]       cnt;
    logic [WIDTH:0]   acc;      // Booth accumulator, one guard bit for -MIN_INT
    logic [WIDTH-1:0] qReg;     // Booth multiplier / divide quotient
    logic             qm1;
    logic [WIDTH-1:0] mcand;    // multiplicand, or |divisor|
    logic [WIDTH-1:0] remReg;
    logic             isDiv;
    logic             signA;
    logic             signB;

    logic [WIDTH:0]   mExt;
    logic [WIDTH:0]   boothSum;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quoNext;

`ifdef MULT_DIV_DIVZERO_EN
    logic             dzPending;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        mExt = {mcand[WIDTH-1], mcand};
        case ({qReg[0], qm1})
            2'b01:   boothSum = acc + mExt;
            2'b10:   boothSum = acc - mExt;
            default: boothSum = acc;
        endcase
        absA = a[WIDTH-1] ? -a : a;
        absB = b[WIDTH-1] ? -b : b;
    end

    div_step #(.WIDTH(WIDTH)) uDivStep (
        .rem     (remReg),
        .quo     (qReg),
        .divisor (mcand),
        .remNext (remNext),
        .quoNext (quoNext)
    );

`ifndef MULT_DIV_DIVZERO_EN
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            qReg   <= '0;
            qm1    <= 1'b0;
            mcand  <= '0;
            remReg <= '0;
            isDiv  <= 1'b0;
            signA  <= 1'b0;
            signB  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
`ifdef MULT_DIV_DIVZERO_EN
            dzPending <= 1'b0;
            div_zero  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MULT_DIV_DIVZERO_EN
            div_zero <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start_mult) begin
                        acc   <= '0;
                        qReg  <= b;
                        qm1   <= 1'b0;
                        mcand <= a;
                        cnt   <= '0;
                        isDiv <= 1'b0;
                        state <= MULT;
                    end else if (start_div) begin
                        remReg <= '0;
                        qReg   <= absA;
                        mcand  <= absB;
                        signA  <= a[WIDTH-1];
                        signB  <= b[WIDTH-1];
                        cnt    <= '0;
                        isDiv  <= 1'b1;
                        state  <= DIV;
                    end
                end
                MULT: begin
                    // arithmetic shift of {acc, Q, Q-1} after the add/subtract
                    acc  <= {boothSum[WIDTH], boothSum[WIDTH:1]};
                    qReg <= {boothSum[0], qReg[WIDTH-1:1]};
                    qm1  <= qReg[0];
                    if (cnt == 6'(MULT_ITER - 1)) state <= DONE;
                    else                          cnt   <= cnt + 6'd1;
                end
                DIV: begin
`ifdef MULT_DIV_DIVZERO_EN
                    if (cnt == '0 && mcand == '0) begin
                        dzPending <= 1'b1;
                        state     <= DONE;
                    end else
`endif
                    begin
                        remReg <= remNext;
                        qReg   <= quoNext;
                        if (cnt == 6'(DIV_ITER - 1)) state <= FIX;
                        else                         cnt   <= cnt + 6'd1;
                    end
                end
                FIX: begin
                    if (signA ^ signB) qReg   <= -qReg;
                    if (signA)         remReg <= -remReg;
                    state <= DONE;
                end
                DONE: begin
`ifdef MULT_DIV_DIVZERO_EN
                    if (dzPending) begin
                        dzPending <= 1'b0;
                        div_zero  <= 1'b1;
                    end else
`endif
                    if (isDiv) begin
                        hi <= remReg;
                        lo <= qReg;
                    end else begin
                        hi <= acc[WIDTH-1:0];
                        lo <= qReg;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Sequential signed multiply/divide unit for the multicycle MIPS datapath. It executes `mult` (radix-2 Booth) and `div` (restoring, sign-corrected) over many cycles and holds the 64-bit result in internal HI/LO registers. It sits beside the ALU, fed from the A/B register outputs. It is consumed by the write-data mux (`mfhi`/`mflo`) and by the control FSM through a start/done handshake.

## Interface
- `WIDTH`, 32, operand and HI/LO width; only 32 is supported.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start_mult` in 1: request a signed multiply. Sampled only in IDLE.
- `start_div` in 1: request a signed divide. Sampled only in IDLE.
- `a` in WIDTH: multiplicand or dividend. Captured on the start edge.
- `b` in WIDTH: multiplier or divisor. Captured on the start edge.
- `hi` out WIDTH: product[63:32] or remainder.
- `lo` out WIDTH: product[31:0] or quotient.
- `busy` out 1: high while an operation is in progress.
- `done` out 1: one-cycle pulse; `hi`/`lo` are valid from this cycle.
- `div_zero` out 1: one-cycle pulse coincident with `done` on a divide by zero.

## Operation
- FSM states are IDLE, MULT, DIV, FIX, DONE.
- **IDLE**
  - If `start_mult` is high: capture `a` and `b`, clear the iteration counter, go to MULT.
  - Else if `start_div` is high: capture `a` and `b`, go to DIV.
  - `start_mult` wins if both are high.
- **MULT**: 32 Booth iterations.
  - Each iteration examines the pair {Q[0], Q−1}.
  - It adds, subtracts or does nothing with the multiplicand on the 33-bit accumulator.
  - It then arithmetic-shifts {acc, Q, Q−1} right by one.
  - After iteration 32, go to DONE.
- **DIV**: operate on |a| and |b| as unsigned values.
  - Run 32 restoring shift-subtract iterations. On a non-negative trial, set the quotient bit and keep the difference; otherwise restore.
  - Then go to FIX.
- **FIX**: apply the sign correction.
  - Quotient is negated iff sign(a) ≠ sign(b).
  - Remainder takes the sign of `a`.
  - Then go to DONE.
- **DONE**: write `hi`/`lo`, pulse `done`, return to IDLE.
- `hi`/`lo` hold their value until the next DONE. They are never disturbed mid-operation.
- Start requests while not in IDLE are ignored; they are not queued.
- Overflow case `0x80000000 / -1`:
  - Result is LO=0x80000000, HI=0.
  - No flag is raised.
- Iteration counter is 6 bits and compares against 31. It never wraps.

## Timing
- Cycle 0 is the clock edge that samples a start in IDLE. `busy` rises after that edge.
- Multiply: `done` and the valid `hi`/`lo` appear in cycle 33, and `busy` falls in that same cycle. The next start is accepted from cycle 33 onward.
- Divide: `done` appears in cycle 34 (32 iterations, FIX, DONE).
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, state IDLE.
- Reset asserted mid-operation aborts immediately:
  - No `done` pulse is produced.
  - `hi`/`lo` return to 0.

## Configuration
- Macro: `MULT_DIV_DIVZERO_EN`.
- **Defined**:
  - When DIV is entered with `b`==0, the unit goes directly to DONE, so `done` and `div_zero` pulse in cycle 2.
  - `hi`/`lo` keep their previous values.
- **Undefined**:
  - `div_zero` is tied to 0.
  - A zero divisor runs the full 34-cycle sequence and gives HI=`a`.
  - LO=0xFFFFFFFF if `a`≥0, otherwise LO=0x00000001.

## Structure
- Package `mult_div_pkg` holds:
  - the state enum;
  - `MULT_ITER`=32 and `DIV_ITER`=32;
  - `MULT_LATENCY`=33 and `DIV_LATENCY`=34.
- One natural combinational sub-module, `div_step`: one restoring shift-subtract step. Inputs are {rem, quo, divisor}; outputs are the next {rem, quo}.
- Booth logic stays inline.

## Test plan
- **Multiply**: `start_mult`, a=7, b=0xFFFFFFFD → `done` in cycle 33, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- **Multiply, MIN_INT**: a=0x80000000, b=0xFFFFFFFF → HI=0x00000000, LO=0x80000000.
- **Signed divide**: `start_div`, a=0xFFFFFFF9 (−7), b=2 → `done` in cycle 34, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **Divide by zero, macro defined**: a=5, b=0, with HI/LO previously 0x11/0x22 → `done` and `div_zero` pulse in cycle 2, HI/LO unchanged.
- **Divide by zero, macro undefined**: same stimulus → cycle 34, HI=5, LO=0xFFFFFFFF.
- **Start while busy, and reset mid-operation**:
  - Pulse `start_div` during MULT → ignored; only one `done`, carrying the mult result.
  - Assert `reset` at cycle 10 of a multiply → `busy`=0 and HI=LO=0 immediately, and no `done` follows.
